// File: rtl/spatial_encoder_sequencer.sv
// Front-end sequencer for spatial_encoder: latches one multi-channel sample, offers it to the encoder,
// then walks the IM/CIM addresses one channel per cycle in lock-step with the encoder's accumulation.
module spatial_encoder_sequencer #(
    parameter int unsigned MAX_CHANNELS = 16,
    parameter int unsigned CH_W         = 5,
    parameter int unsigned LEVEL_W      = 5,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_sample_valid,
    output logic                            o_sample_ready,
    input  logic [MAX_CHANNELS*LEVEL_W-1:0] i_sample_levels,
    input  logic [CH_W-1:0]                 i_sample_num_ch,
    output logic [CH_W-1:0]                 o_im_addr,
    output logic [LEVEL_W-1:0]              o_cim_addr,
    output logic                            o_enc_din_valid,
    input  logic                            i_enc_din_ready,
    output logic [CH_W-1:0]                 o_enc_num_channel,
    output logic                            o_busy,
    output logic                            o_cfg_err,
    output logic [CNT_W-1:0]                o_samples_encoded
);

    localparam int unsigned IDX_W = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFER  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t               r_state;
    logic [LEVEL_W-1:0]   r_levels [MAX_CHANNELS];
    logic [CH_W-1:0]      r_ch_idx;
    logic [CH_W-1:0]      r_n_lat;
    logic                 r_cfg_err;
    logic [CNT_W-1:0]     r_count;

    logic                 w_sample_fire;
    logic                 w_cfg_bad;
    logic [CH_W-1:0]      w_n_clamped;
    logic                 w_last_ch;

    assign w_sample_fire = i_sample_valid && o_sample_ready;
    assign w_cfg_bad     = (i_sample_num_ch < CH_W'(2));
    assign w_n_clamped   = (i_sample_num_ch > CH_W'(MAX_CHANNELS)) ? CH_W'(MAX_CHANNELS) : i_sample_num_ch;
    assign w_last_ch     = (r_ch_idx == (r_n_lat - CH_W'(1)));

    // Sequencer FSM; ch_idx doubles as the item-memory address so the address ports never see enc_din_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ch_idx  <= '0;
            r_n_lat   <= '0;
            r_cfg_err <= 1'b0;
            r_count   <= '0;
            for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
                r_levels[k] <= '0;
            end
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sample_fire) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
                                r_levels[k] <= i_sample_levels[k*LEVEL_W +: LEVEL_W];
                            end
                            r_n_lat  <= w_n_clamped;
                            r_ch_idx <= '0;
                            r_state  <= S_OFFER;
                        end
                    end
                end
                S_OFFER: begin
                    if (i_enc_din_ready) begin
                        r_ch_idx <= CH_W'(1);
                        r_count  <= r_count + CNT_W'(1);
                        r_state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Last channel holds ch_idx so the addresses stay put while idle.
                    if (w_last_ch) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ch_idx <= r_ch_idx + CH_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake/status outputs are masked by rst so they drop in the reset cycle itself.
    assign o_sample_ready    = (r_state == S_IDLE)  && !rst;
    assign o_enc_din_valid   = (r_state == S_OFFER) && !rst;
    assign o_busy            = (r_state != S_IDLE)  && !rst;
    assign o_cfg_err         = r_cfg_err && !rst;
    assign o_im_addr         = r_ch_idx;
    assign o_cim_addr        = r_levels[r_ch_idx[IDX_W-1:0]];
    assign o_enc_num_channel = r_n_lat;
    assign o_samples_encoded = r_count;

endmodule

// File: tb/tb_spatial_encoder_sequencer.sv
// Bench for spatial_encoder_sequencer: directed vector table, reset corner cases and random samples
// checked against a channel-stream and majority-bundle model.
module tb_spatial_encoder_sequencer;

    localparam int unsigned MAXC = 16;
    localparam int unsigned CH_W = 5;
    localparam int unsigned LW   = 5;
    localparam int unsigned CW   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_sample_valid;
    logic               o_sample_ready;
    logic [MAXC*LW-1:0] i_sample_levels;
    logic [CH_W-1:0]    i_sample_num_ch;
    logic [CH_W-1:0]    o_im_addr;
    logic [LW-1:0]      o_cim_addr;
    logic               o_enc_din_valid;
    logic               i_enc_din_ready;
    logic [CH_W-1:0]    o_enc_num_channel;
    logic               o_busy;
    logic               o_cfg_err;
    logic [CW-1:0]      o_samples_encoded;

    spatial_encoder_sequencer #(
        .MAX_CHANNELS(MAXC), .CH_W(CH_W), .LEVEL_W(LW), .CNT_W(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_sample_valid   (i_sample_valid),
        .o_sample_ready   (o_sample_ready),
        .i_sample_levels  (i_sample_levels),
        .i_sample_num_ch  (i_sample_num_ch),
        .o_im_addr        (o_im_addr),
        .o_cim_addr       (o_cim_addr),
        .o_enc_din_valid  (o_enc_din_valid),
        .i_enc_din_ready  (i_enc_din_ready),
        .o_enc_num_channel(o_enc_num_channel),
        .o_busy           (o_busy),
        .o_cfg_err        (o_cfg_err),
        .o_samples_encoded(o_samples_encoded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  num_ch;
        logic [79:0] lv;
        int          stall;
        int          exp_n;
        bit          exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_count = 0;
    logic [15:0] im_tab  [32];
    logic [15:0] cim_tab [32];
    vec_t        tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [79:0] rand_lv();
        return {16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // Bitwise majority of bound hypervectors; ties resolve to 0.
    function automatic logic [15:0] majority(input logic [15:0] hvs[$]);
        logic [15:0] res;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            int cnt;
            cnt = 0;
            foreach (hvs[i]) cnt += int'(hvs[i][b]);
            res[b] = (2 * cnt > hvs.size());
        end
        return res;
    endfunction

    task automatic wait_ready(input string tag, output bit ok);
        int cyc;
        cyc = 0;
        while (o_sample_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        ok = (o_sample_ready === 1'b1);
        if (!ok) check({tag, " ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Offers one sample and follows it through OFFER/STREAM, comparing every cycle.
    task automatic run_sample(input logic [4:0] num_ch, input logic [79:0] lv, input int stall,
                              input int exp_n, input bit exp_err, input string tag);
        logic [15:0] got_hv[$];
        logic [15:0] exp_hv[$];
        logic [4:0]  lvk;
        bit          ok;
        wait_ready(tag, ok);
        if (!ok) return;
        i_sample_valid  = 1'b1;
        i_sample_levels = lv;
        i_sample_num_ch = num_ch;
        @(negedge clk);
        i_sample_valid  = 1'b0;
        i_sample_levels = rand_lv();
        if (exp_err) begin
            check({tag, " cfg_err"}, 32'(o_cfg_err), 32'd1);
            check({tag, " err_busy"}, 32'(o_busy), 32'd0);
            check({tag, " err_valid"}, 32'(o_enc_din_valid), 32'd0);
            check({tag, " err_count"}, 32'(o_samples_encoded), 32'(exp_count));
            @(negedge clk);
            check({tag, " cfg_err_pulse"}, 32'(o_cfg_err), 32'd0);
            return;
        end
        check({tag, " busy"}, 32'(o_busy), 32'd1);
        check({tag, " num_channel"}, 32'(o_enc_num_channel), 32'(exp_n));
        check({tag, " ready_low"}, 32'(o_sample_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            i_enc_din_ready = 1'b0;
            i_sample_valid  = 1'b1;
            i_sample_num_ch = 5'($urandom_range(2, 16));
            check({tag, " stall_valid"}, 32'(o_enc_din_valid), 32'd1);
            check({tag, " stall_im"}, 32'(o_im_addr), 32'd0);
            check({tag, " stall_cim"}, 32'(o_cim_addr), 32'(lv[4:0]));
            @(negedge clk);
        end
        i_sample_valid  = 1'b0;
        i_enc_din_ready = 1'b1;
        check({tag, " offer_valid"}, 32'(o_enc_din_valid), 32'd1);
        check({tag, " offer_im"}, 32'(o_im_addr), 32'd0);
        check({tag, " offer_cim"}, 32'(o_cim_addr), 32'(lv[4:0]));
        got_hv.push_back(im_tab[o_im_addr] ^ cim_tab[o_cim_addr]);
        @(negedge clk);
        exp_count = (exp_count + 1) % 65536;
        for (int k = 1; k < exp_n; k++) begin
            lvk = lv[k*5 +: 5];
            check({tag, " stream_im"}, 32'(o_im_addr), 32'(k));
            check({tag, " stream_cim"}, 32'(o_cim_addr), 32'(lvk));
            check({tag, " stream_valid"}, 32'(o_enc_din_valid), 32'd0);
            got_hv.push_back(im_tab[o_im_addr] ^ cim_tab[o_cim_addr]);
            @(negedge clk);
        end
        check({tag, " done_ready"}, 32'(o_sample_ready), 32'd1);
        check({tag, " done_busy"}, 32'(o_busy), 32'd0);
        check({tag, " count"}, 32'(o_samples_encoded), 32'(exp_count));
        check({tag, " num_channel_hold"}, 32'(o_enc_num_channel), 32'(exp_n));
        for (int k = 0; k < exp_n; k++) begin
            lvk = lv[k*5 +: 5];
            exp_hv.push_back(im_tab[k] ^ cim_tab[lvk]);
        end
        check({tag, " hv"}, 32'(majority(got_hv)), 32'(majority(exp_hv)));
    endtask

    initial begin
        bit          ok;
        logic [79:0] lv1;
        int          nc;

        foreach (im_tab[i])  im_tab[i]  = 16'($urandom);
        foreach (cim_tab[i]) cim_tab[i] = 16'($urandom);

        rst = 1'b1; i_sample_valid = 1'b0; i_sample_levels = '0; i_sample_num_ch = '0; i_enc_din_ready = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(o_sample_ready), 32'd0);
        check("rst_valid", 32'(o_enc_din_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(o_sample_ready), 32'd1);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_im", 32'(o_im_addr), 32'd0);
        check("reset_cim", 32'(o_cim_addr), 32'd0);
        check("reset_num", 32'(o_enc_num_channel), 32'd0);
        check("reset_count", 32'(o_samples_encoded), 32'd0);
        check("reset_cfg_err", 32'(o_cfg_err), 32'd0);
        @(negedge clk);

        lv1 = '0;
        lv1[4:0] = 5'd3; lv1[9:5] = 5'd7; lv1[14:10] = 5'd0; lv1[19:15] = 5'd31;
        tbl[0] = '{5'd4,  lv1,       0, 4,  1'b0};
        tbl[1] = '{5'd4,  lv1,       5, 4,  1'b0};
        tbl[2] = '{5'd1,  rand_lv(), 0, 0,  1'b1};
        tbl[3] = '{5'd0,  rand_lv(), 0, 0,  1'b1};
        tbl[4] = '{5'd20, rand_lv(), 0, 16, 1'b0};
        tbl[5] = '{5'd2,  rand_lv(), 1, 2,  1'b0};
        tbl[6] = '{5'd16, rand_lv(), 2, 16, 1'b0};
        tbl[7] = '{5'd31, rand_lv(), 0, 16, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_sample(tbl[i].num_ch, tbl[i].lv, tbl[i].stall, tbl[i].exp_n, tbl[i].exp_err,
                       $sformatf("vec%0d", i));
        end

        // Reset while streaming channel 2.
        wait_ready("rst_stream", ok);
        i_sample_valid = 1'b1; i_sample_levels = rand_lv(); i_sample_num_ch = 5'd6; i_enc_din_ready = 1'b1;
        @(negedge clk);
        i_sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_stream_im", 32'(o_im_addr), 32'd2);
        rst = 1'b1;
        #1;
        check("rst_stream_ready_low", 32'(o_sample_ready), 32'd0);
        @(negedge clk);
        check("rst_stream_busy", 32'(o_busy), 32'd0);
        check("rst_stream_count", 32'(o_samples_encoded), 32'd0);
        check("rst_stream_im0", 32'(o_im_addr), 32'd0);
        check("rst_stream_num0", 32'(o_enc_num_channel), 32'd0);
        rst = 1'b0;
        exp_count = 0;
        #1;
        check("rst_stream_ready", 32'(o_sample_ready), 32'd1);
        @(negedge clk);

        // Reset while offering: enc_din_valid must drop in the same cycle.
        i_sample_valid = 1'b1; i_sample_levels = rand_lv(); i_sample_num_ch = 5'd5; i_enc_din_ready = 1'b0;
        @(negedge clk);
        i_sample_valid = 1'b0;
        check("rst_offer_valid", 32'(o_enc_din_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_offer_valid_drop", 32'(o_enc_din_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_enc_din_ready = 1'b1;
        #1;
        check("rst_offer_idle", 32'(o_busy), 32'd0);
        check("rst_offer_count", 32'(o_samples_encoded), 32'd0);
        @(negedge clk);

        // Back-to-back three-channel samples.
        for (int i = 0; i < 6; i++) run_sample(5'd3, rand_lv(), 0, 3, 1'b0, $sformatf("b2b%0d", i));

        // Random samples against the model.
        for (int i = 0; i < 40; i++) begin
            nc = $urandom_range(0, 20);
            run_sample(5'(nc), rand_lv(), $urandom_range(0, 3), (nc > 16) ? 16 : nc, (nc < 2),
                       $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
